// File: rtl/canny_window_if.sv
// Pixel-source / line-buffer / window-strobe bundle for canny_window_ctrl.
// The master is the pixel source and window consumer; the slave is the controller.
interface canny_window_if #(
  parameter int W = 8
);
  logic         start;
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_pixel;
  logic         in_eol;
  logic         out_ready;
  logic         lb_ce;
  logic [W-1:0] lb_pixel;
  logic         lb_clear;
  logic         win_valid;
  logic [15:0]  win_row;
  logic [15:0]  win_col;
  logic         busy;
  logic         frame_done;
  logic         sync_err;

  modport master (
    output start, abort, in_valid, in_pixel, in_eol, out_ready,
    input  in_ready, lb_ce, lb_pixel, lb_clear, win_valid, win_row, win_col,
           busy, frame_done, sync_err
  );

  modport slave (
    input  start, abort, in_valid, in_pixel, in_eol, out_ready,
    output in_ready, lb_ce, lb_pixel, lb_clear, win_valid, win_row, win_col,
           busy, frame_done, sync_err
  );
endinterface

// File: rtl/canny_window_ctrl.sv
// Sequencer for the Canny 3x3 window line buffer: pixel handshake, frame position, drain, window strobe.
// Optional WIN_STALL_CNT_EN adds a saturating stall_cnt port counting RUN/FLUSH cycles without lb_ce.
module canny_window_ctrl #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int LB_LAT = 2,
  parameter int W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  canny_window_if.slave bus
`ifdef WIN_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(LB_LAT + 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(LB_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [FW-1:0]     r_flush_cnt;
  logic              r_abort_clr;
  logic              r_sync_err;
  logic              r_win_valid;
  logic [15:0]       r_win_row;
  logic [15:0]       r_win_col;
  logic [LB_LAT-1:0] r_vld_p;
  logic [RW-1:0]     r_row_p [LB_LAT];
  logic [CW-1:0]     r_col_p [LB_LAT];

  logic w_abort;
  logic w_start_ok;
  logic w_accept;
  logic w_last;
  logic w_ce;
  logic w_push_vld;
  logic w_strobe;

  // Abort only matters once a frame is under way, and beats start/accept in the same cycle.
  assign w_abort    = bus.abort & (r_state != S_IDLE);
  assign w_start_ok = bus.start & ~bus.abort & (r_state == S_IDLE);
  assign w_accept   = bus.in_valid & bus.in_ready;
  assign w_last     = (r_row == ROW_LAST) & (r_col == COL_LAST);

  always_comb begin
    w_ce = 1'b0;
    if (!w_abort) begin
      if (r_state == S_RUN)        w_ce = w_accept;
      else if (r_state == S_FLUSH) w_ce = bus.out_ready;
    end
  end

  assign bus.in_ready   = (r_state == S_RUN) & bus.out_ready & ~bus.abort;
  assign bus.lb_ce      = w_ce;
  assign bus.lb_pixel   = (r_state == S_RUN) ? bus.in_pixel : '0;
  assign bus.lb_clear   = (r_state == S_CLEAR) | r_abort_clr;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.frame_done = (r_state == S_DONE) & ~bus.abort;
  assign bus.sync_err   = r_sync_err;
  assign bus.win_valid  = r_win_valid;
  assign bus.win_row    = r_win_row;
  assign bus.win_col    = r_win_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start_ok) w_next = S_CLEAR;
        S_CLEAR: w_next = S_RUN;
        S_RUN:   if (w_accept && w_last) w_next = S_FLUSH;
        S_FLUSH: if (w_ce && (r_flush_cnt == FLUSH_LAST)) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row       <= '0;
      r_col       <= '0;
      r_flush_cnt <= '0;
      r_abort_clr <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_abort_clr <= w_abort;
      if (w_start_ok)
        r_sync_err <= 1'b0;
      else if (w_accept && (bus.in_eol != (r_col == COL_LAST)))
        r_sync_err <= 1'b1;
      if (r_state == S_CLEAR) begin
        r_row       <= '0;
        r_col       <= '0;
        r_flush_cnt <= '0;
      end else if (w_accept) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if ((r_state == S_FLUSH) && w_ce) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Tag pipe: mirrors the line buffer latency so a tag reaches the tail when its window is complete.
  assign w_push_vld = w_accept & (r_row >= RW'(2)) & (r_col >= CW'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p <= '0;
    end else if (r_state == S_CLEAR) begin
      r_vld_p <= '0;
    end else if (w_ce) begin
      r_vld_p[0] <= w_push_vld;
      for (int i = 1; i < LB_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_ce) begin
      r_row_p[0] <= r_row - 1'b1;
      r_col_p[0] <= r_col - 1'b1;
      for (int i = 1; i < LB_LAT; i++) begin
        r_row_p[i] <= r_row_p[i-1];
        r_col_p[i] <= r_col_p[i-1];
      end
    end
  end

  // Strobe stage: registered from the tail on the ce that completes the window.
  assign w_strobe = w_ce & r_vld_p[LB_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else begin
      r_win_valid <= w_strobe;
      if (w_strobe) begin
        r_win_row <= 16'(r_row_p[LB_LAT-1]);
        r_win_col <= 16'(r_col_p[LB_LAT-1]);
      end
    end
  end

`ifdef WIN_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (r_state == S_CLEAR)
      r_stall_cnt <= '0;
    else if (((r_state == S_RUN) || (r_state == S_FLUSH)) && !w_ce && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_canny_window_ctrl.sv
// Randomized bench for canny_window_ctrl on an 8x8 frame against a raster-order window-centre model.
module tb_canny_window_ctrl;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int LB_LAT = 2;
  localparam int W      = 8;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NWIN   = (IMG_W - 2) * (IMG_H - 2);

  typedef struct {
    int r;
    int c;
  } ctr_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
`ifdef WIN_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  canny_window_if #(.W(W)) bus ();

  canny_window_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .LB_LAT(LB_LAT),
    .W     (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef WIN_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check_eq("clear_pulse", bus.lb_clear, 1);
    check_eq("clear_busy", bus.busy, 1);
    check_eq("start_clears_sync", bus.sync_err, 0);
  endtask

  task automatic run_frame(input int gap_pct, input bit bad_eol, input int abort_idx,
                           input bit start_mid, input bit rst_flush, input bit stall10);
    ctr_t q[$];
    ctr_t e;
    int   idx, cyc, nwin, ndone, acc_c, first_c, last_c, done_c, stall_left;
    bit   stop, aborted, reset_hit;
    idx = 0; cyc = 0; nwin = 0; ndone = 0;
    acc_c = -1; first_c = -1; last_c = -1; done_c = -1;
    stall_left = stall10 ? 10 : 0;
    stop = 0; aborted = 0; reset_hit = 0;
    for (int r = 1; r <= IMG_H - 2; r++)
      for (int c = 1; c <= IMG_W - 2; c++) q.push_back('{r, c});

    do_start();
    while (!stop && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      bus.in_valid  = (idx < NPIX) && ($urandom_range(99) >= gap_pct);
      bus.out_ready = ($urandom_range(99) >= gap_pct);
      if (stall10 && idx >= 10 && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end
      bus.in_pixel = W'(idx);
      bus.in_eol   = ((idx % IMG_W) == IMG_W - 1) || (bad_eol && idx == 3 * IMG_W + 6);
      bus.start    = start_mid && (idx == 20);
      bus.abort    = (abort_idx >= 0) && (idx == abort_idx);
      @(negedge clk);
      if (bus.abort) begin
        check_eq("abort_blocks_ce", bus.lb_ce, 0);
        @(posedge clk); #1;
        bus.abort = 1'b0; bus.in_valid = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_clear", bus.lb_clear, 1);
        check_eq("abort_no_done", bus.frame_done, 0);
        @(negedge clk);
        check_eq("abort_clear_1cyc", bus.lb_clear, 0);
        aborted = 1; stop = 1;
      end else begin
        if (bus.in_valid && bus.in_ready) begin
          check_eq("accept_ce", bus.lb_ce, 1);
          check_eq("lb_pixel", bus.lb_pixel, idx);
          if (idx == 2 * IMG_W + 2) acc_c = cyc;
          last_c = cyc;
          idx++;
        end
        if (bus.lb_ce) check_eq("ce_needs_ready", bus.out_ready, 1);
        if (bus.win_valid) begin
          nwin++;
          if (first_c < 0) first_c = cyc;
          e = (q.size() > 0) ? q.pop_front() : '{0, 0};
          check_eq("win_row", bus.win_row, e.r);
          check_eq("win_col", bus.win_col, e.c);
        end
        if (bus.frame_done) begin
          ndone++; done_c = cyc; stop = 1;
        end
        if (rst_flush && idx == NPIX && cyc == last_c + 1) begin
          rst = 1'b1;
          #1;
          check_eq("rst_ctl_outs", {bus.busy, bus.lb_ce, bus.lb_clear, bus.win_valid,
                                    bus.frame_done, bus.sync_err, bus.in_ready}, 0);
          check_eq("rst_win_row", bus.win_row, 0);
          check_eq("rst_win_col", bus.win_col, 0);
          check_eq("rst_lb_pixel", bus.lb_pixel, 0);
          #1;
          rst = 1'b0;
          reset_hit = 1; stop = 1;
        end
      end
    end
    bus.in_valid = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b1;

    if (!aborted && !reset_hit) begin
      check_eq("frame_done_count", ndone, 1);
      check_eq("win_count", nwin, NWIN);
      check_eq("win_missing", q.size(), 0);
      check_eq("sync_err_end", bus.sync_err, bad_eol);
      if (gap_pct == 0) begin
        check_eq("first_win_latency", first_c - acc_c, LB_LAT + 1);
        check_eq("done_latency", done_c - last_c, LB_LAT + 1);
      end
`ifdef WIN_STALL_CNT_EN
      if (stall10) check_eq("stall_cnt", stall_cnt, 10);
`endif
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check_eq("idle_busy", bus.busy, 0);
      check_eq("idle_in_ready", bus.in_ready, 0);
      check_eq("idle_ce", bus.lb_ce, 0);
      check_eq("done_1cyc", bus.frame_done, 0);
      check_eq("sync_err_held", bus.sync_err, bad_eol);
      bus.in_valid = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0;
    bus.in_pixel = '0; bus.in_eol = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_ctl_outs", {bus.busy, bus.lb_ce, bus.lb_clear, bus.win_valid,
                                bus.frame_done, bus.sync_err, bus.in_ready}, 0);
    check_eq("reset_win_row", bus.win_row, 0);
    check_eq("reset_win_col", bus.win_col, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(0,  1'b0, -1,             1'b0, 1'b0, 1'b0);
    run_frame(30, 1'b0, -1,             1'b0, 1'b0, 1'b0);
    run_frame(20, 1'b1, -1,             1'b1, 1'b0, 1'b0);
    run_frame(20, 1'b0, 4 * IMG_W + 3,  1'b0, 1'b0, 1'b0);
    run_frame(25, 1'b0, -1,             1'b0, 1'b0, 1'b0);
    run_frame(0,  1'b0, -1,             1'b0, 1'b0, 1'b1);
    run_frame(0,  1'b1, -1,             1'b0, 1'b1, 1'b0);
    run_frame(0,  1'b0, -1,             1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
